// File: rtl/sync_mod_counter.sv
// sync_mod_counter: WIDTH-bit modulus counter with clear/load/enp/ent, ripple carry and wrap pulse; COUNTER_UPDOWN_EN adds down counting
module sync_mod_counter #(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);
  localparam logic [WIDTH:0]   last_x = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] last_q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] rst_q  = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] step;
  logic at_last, step_wrap;
  // one extra bit so MODULUS = 2^WIDTH compares without overflow
  assign at_last = {1'b0, q} >= last_x;
`ifdef COUNTER_UPDOWN_EN
  assign step_wrap = up_dn ? at_last : (q == '0);
  assign step      = up_dn ? (at_last ? '0 : q + 1'b1) : (q == '0 ? last_q : q - 1'b1);
  assign rco       = ent & (up_dn ? ({1'b0, q} == last_x) : (q == '0));
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
  assign step_wrap    = at_last;
  assign step         = at_last ? '0 : q + 1'b1;
  assign rco          = ent & ({1'b0, q} == last_x);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= rst_q;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (ld) begin
      q    <= d;
      wrap <= 1'b0;
    end else if (enp & ent) begin
      q    <= step;
      wrap <= step_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sync_mod_counter.sv
// tb_sync_mod_counter: directed and random checks of a cascaded mod-10 pair and a mod-16 slice against an arithmetic model
module tb_sync_mod_counter;
  logic clk = 0, rst = 0, clr = 0, ld = 0, enp = 0, ent = 0, up_dn = 1;
  logic [3:0] d = 0, d_b = 0;
  logic [3:0] q_a, q_b, q_c;
  logic rco_a, rco_b, rco_c, wrap_a, wrap_b, wrap_c;
  int checks = 0, errors = 0;
  int ma = 0, mb = 0, mc = 0;
  bit wa = 0, wb = 0, wc = 0, init = 0;

  always #5 clk = ~clk;

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .enp(enp), .ent(ent),
    .up_dn(up_dn), .q(q_a), .rco(rco_a), .wrap(wrap_a));
  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d_b), .enp(enp), .ent(rco_a),
    .up_dn(up_dn), .q(q_b), .rco(rco_b), .wrap(wrap_b));
  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .enp(enp), .ent(ent),
    .up_dn(up_dn), .q(q_c), .rco(rco_c), .wrap(wrap_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // next count value from the priority rules, with modulus m and reset value rv
  function automatic void nxt(input int m, input int rv, input int cur, input bit cnt,
                              input bit up, input int dd, output int nq, output bit nw);
    nw = 0;
    nq = cur;
    if (rst) nq = rv;
    else if (clr) nq = 0;
    else if (ld) nq = dd;
    else if (cnt) begin
      if (up) begin
        nw = cur >= m - 1;
        nq = nw ? 0 : cur + 1;
      end else begin
        nw = cur == 0;
        nq = nw ? m - 1 : cur - 1;
      end
    end
  endfunction

  task automatic cyc();
    bit up, ra, rb, rc, xa, xb, xc;
    int na, nb, nc;
`ifdef COUNTER_UPDOWN_EN
    up = up_dn;
`else
    up = 1;
`endif
    ra = ent && ma == (up ? 9 : 0);
    rb = ra && mb == (up ? 9 : 0);
    rc = ent && mc == (up ? 15 : 0);
    #1;
    if (init) begin
      chk("rco_a", rco_a, ra);
      chk("rco_b", rco_b, rb);
      chk("rco_c", rco_c, rc);
    end
    nxt(10, 0, ma, enp && ent, up, int'(d), na, xa);
    nxt(10, 0, mb, enp && ra, up, int'(d_b), nb, xb);
    nxt(16, 3, mc, enp && ent, up, int'(d), nc, xc);
    @(posedge clk);
    #1;
    ma = na; mb = nb; mc = nc; wa = xa; wb = xb; wc = xc; init = 1;
    chk("q_a", q_a, ma);
    chk("wrap_a", wrap_a, wa);
    chk("q_b", q_b, mb);
    chk("wrap_b", wrap_b, wb);
    chk("q_c", q_c, mc);
    chk("wrap_c", wrap_c, wc);
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 1;
    cyc();
    chk("reset_q_c", q_c, 3);
    rst = 0; enp = 1; ent = 1; up_dn = 1;
    for (int i = 0; i < 9; i++) cyc();
    #1;
    chk("rco_at_9", rco_a, 1);
    cyc();
    chk("wrap_to_0", q_a, 0);
    chk("wrap_pulse", wrap_a, 1);
    cyc();
    chk("wrap_one_cycle", wrap_a, 0);
    ld = 1; d = 9; cyc();
    ld = 0; ent = 0; cyc();
    chk("hold_ent0", q_a, 9);
    chk("rco_ent0", rco_a, 0);
    ent = 1; enp = 0; cyc();
    chk("hold_enp0", q_a, 9);
    chk("rco_enp0", rco_a, 1);
    clr = 1; ld = 1; d = 5; cyc();
    chk("clr_over_ld", q_a, 0);
    clr = 0; enp = 1; cyc();
    chk("ld_over_count", q_a, 5);
    chk("ld_no_wrap", wrap_a, 0);
    d = 13; cyc();
    ld = 0; cyc();
    chk("oor_wrap_q", q_a, 0);
    chk("oor_wrap_pulse", wrap_a, 1);
    chk("mod16_q", q_c, 14);
    clr = 1; cyc();
    clr = 0;
    for (int i = 0; i < 25; i++) cyc();
    chk("cascade_lo", q_a, 5);
    chk("cascade_hi", q_b, 2);
`ifdef COUNTER_UPDOWN_EN
    clr = 1; cyc();
    clr = 0; up_dn = 0;
    #1;
    chk("dn_rco_at_0", rco_a, 1);
    cyc();
    chk("dn_wrap_q", q_a, 9);
    chk("dn_wrap_pulse", wrap_a, 1);
    cyc(); cyc();
    rst = 1; cyc();
    chk("mid_rst", q_a, 0);
    rst = 0; cyc();
    chk("after_rst", q_a, 9);
`else
    up_dn = 0; cyc();
    chk("up_dn_ignored", q_a, 6);
`endif
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 39) == 0;
      clr = $urandom_range(0, 15) == 0;
      ld = $urandom_range(0, 7) == 0;
      d = 4'($urandom_range(0, 15));
      d_b = 4'($urandom_range(0, 15));
      enp = $urandom_range(0, 4) != 0;
      ent = $urandom_range(0, 4) != 0;
      up_dn = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_mod_counter.md
Name: sync_mod_counter

Overview:
- Parametrised successor of the 4-bit loadable synchronous counter slice.
- Provides a WIDTH-bit registered counter with a programmable modulus, synchronous clear, parallel load, and dual count enables (enp/ent).
- Provides a combinational ripple-carry output for cascading slices.
- Used in ReRAM-mapping benchmark datapaths as the standard counter primitive. Replaces hand-built 4-bit slices.

Parameters:
- WIDTH, 4, counter register width in bits (2..32).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2^WIDTH; MODULUS=2^WIDTH gives a pure binary counter.
- RESET_VAL, 0, value loaded into q on rst. Must be < MODULUS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of q to 0.
- ld  input  1  synchronous parallel load of d.
- d  input  WIDTH  load data.
- enp  input  1  count enable, parallel (does not gate rco).
- ent  input  1  count enable, trickle (gates rco).
- up_dn  input  1  direction: 1 = up, 0 = down. Only used when COUNTER_UPDOWN_EN is defined.
- q  output  WIDTH  registered count.
- rco  output  1  ripple carry out, combinational.
- wrap  output  1  registered one-cycle pulse; high in the cycle after q wrapped due to counting.

Behaviour:
- Reset values: q=RESET_VAL, wrap=0. rco follows its equation from the reset value.
- Priority at each rising clk edge: rst > clr > ld > count > hold.
  - rst: q<=RESET_VAL, wrap<=0.
  - clr: q<=0, wrap<=0.
  - ld: q<=d, loaded verbatim with no modulus check; wrap<=0.
  - count when enp & ent: q advances one step in the current direction.
  - otherwise: q holds, wrap<=0.
- Terminal count TC is MODULUS-1 in up mode and 0 in down mode.
- Up step:
  - If q >= MODULUS-1, q<=0 and wrap<=1.
  - Else q<=q+1 and wrap<=0.
  - An out-of-range loaded value therefore wraps to 0 on the next up count.
- Down step:
  - If q == 0, q<=MODULUS-1 and wrap<=1.
  - Else q<=q-1 and wrap<=0.
  - An out-of-range loaded value decrements normally.
- rco = ent & (q == TC), purely combinational, zero latency. It is independent of enp, clr, ld, and rst.
- Cascading: slice k+1 takes ent from rco of slice k and shares enp. This gives a synchronous multi-digit counter with no extra delay.
- Simultaneous clr and ld: clr wins. Simultaneous ld and count: ld wins and wrap=0.
- rst asserted mid-count: takes effect at the next edge; q continues from RESET_VAL after release.
- Arithmetic is internally WIDTH+1 bits, so no overflow artefacts at MODULUS=2^WIDTH.

Optional Feature:
- Macro: COUNTER_UPDOWN_EN.
- Defined: up_dn selects direction each cycle. A direction change takes effect on the next counting edge, and rco re-evaluates immediately against the new TC.
- Undefined: up_dn is ignored (port kept for a stable interface). The counter is up-only, TC=MODULUS-1, and the decrement path is not synthesised.

Test Plan:
1. Wrap at modulus (WIDTH=4, MODULUS=10): rst, then enp=ent=1 for 10 cycles → q steps 0..9 then 0. rco=1 while q=9. wrap=1 in exactly the one cycle where q=0 after the wrap.
2. Enable gating: q=9, ent=0, enp=1 → q holds 9, rco=0. Then ent=1, enp=0 → q holds 9, rco=1.
3. Priority: clr=1, ld=1, d=5 → q=0. Next cycle clr=0, ld=1, enp=ent=1, d=5 → q=5, wrap=0.
4. Out-of-range load (MODULUS=10): ld with d=13, then one up count → q=0, wrap=1.
5. Cascade: two slices (MODULUS=10), low slice rco driving high slice ent. Count from 00 for 25 cycles → high=2, low=5. High slice increments only on the edges where low=9.
6. With COUNTER_UPDOWN_EN, up_dn=0: q=0 → next count gives q=9, wrap=1, rco=1 while q=0. Synchronous rst mid-sequence → q=RESET_VAL on the following edge.
